jtframe_data_io: RTL and testbench

Parametrised, single-clock successor to the MiST SPI file-download receiver. The block oversamples the I/O controller SPI lines in the system clock domain and decodes the file-transfer commands. Downloaded bytes are buffered in a small FIFO, packed into DW-bit words, and presented to the SDRAM loader through a valid/ready write port, so the loader can stall without losing data.

---
 rtl/jtframe_data_io.sv | 190 +++++++++++++++++++
 tb/tb_jtframe_data_io.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_data_io.sv
// rtl/jtframe_data_io.sv - MiST SPI file-download receiver with FIFO-buffered, stallable SDRAM write port
// Optional: define JTFRAME_DATA_IO_SUM_EN to drive a running byte checksum on ioctl_sum.
module jtframe_data_io #(
  parameter int DW    = 8,
  parameter int AW    = 23,
  parameter int DEPTH = 16
) (
  input  logic          clk_sdram,
  input  logic          rst,
  input  logic          sck,
  input  logic          ss,
  input  logic          sdi,
  output logic [7:0]    index,
  output logic          downloading,
  output logic [AW-1:0] ioctl_addr,
  output logic [DW-1:0] ioctl_data,
  output logic          ioctl_wr,
  input  logic          ioctl_ready,
  output logic          ioctl_err,
  output logic [15:0]   ioctl_sum
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [7:0] FILE_TX     = 8'h53;
  localparam logic [7:0] FILE_TX_DAT = 8'h54;
  localparam logic [7:0] FILE_INDEX  = 8'h55;

  typedef enum logic [1:0] {IDLE, HALF, WRITE} state_t;

  logic [1:0]    sck_sync, ss_sync, sdi_sync;
  logic          sck_last, sck_rise, ss_s, sdi_s;
  logic [4:0]    bit_cnt;
  logic [6:0]    shift;
  logic [7:0]    cmd, rx_byte;
  logic          byte_done, tx_start, tx_end, push_req;
  logic          push_ok, pop, overflow;
  logic          end_pend;
  state_t        state;
  logic [15:0]   word;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          fifo_empty, fifo_full;
  logic [7:0]    head;

  assign ss_s      = ss_sync[1];
  assign sdi_s     = sdi_sync[1];
  assign sck_rise  = sck_sync[1] & ~sck_last;
  assign rx_byte   = {shift, sdi_s};
  assign byte_done = sck_rise & ~ss_s & (bit_cnt == 5'd15);
  assign tx_start  = byte_done & (cmd == FILE_TX) & rx_byte[0];
  assign tx_end    = byte_done & (cmd == FILE_TX) & ~rx_byte[0];
  assign push_req  = byte_done & (cmd == FILE_TX_DAT) & downloading & ~end_pend;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (PW+1)'(DEPTH));
  assign head       = mem[rd_ptr];
  // A start flushes the FIFO, so it must not also consume the head entry.
  assign pop        = ~tx_start & ~fifo_empty & ((state == IDLE) | (state == HALF));
  assign push_ok    = push_req & (~fifo_full | pop);
  assign overflow   = push_req & fifo_full & ~pop;

  always_ff @(posedge clk_sdram or posedge rst) begin
    if (rst) begin
      sck_sync <= 2'b00;
      ss_sync  <= 2'b11;
      sdi_sync <= 2'b00;
      sck_last <= 1'b0;
      bit_cnt  <= 5'd0;
      shift    <= 7'd0;
      cmd      <= 8'd0;
      index    <= 8'd0;
    end else begin
      sck_sync <= {sck_sync[0], sck};
      ss_sync  <= {ss_sync[0], ss};
      sdi_sync <= {sdi_sync[0], sdi};
      sck_last <= sck_sync[1];
      if (ss_s) begin
        bit_cnt <= 5'd0;
      end else if (sck_rise) begin
        // After the command byte the counter loops over 8..15, one data byte per lap
        bit_cnt <= (bit_cnt == 5'd15) ? 5'd8 : bit_cnt + 5'd1;
        shift   <= rx_byte[6:0];
        if (bit_cnt == 5'd7) cmd <= rx_byte;
        if (byte_done && cmd == FILE_INDEX) index <= rx_byte;
      end
    end
  end

  always_ff @(posedge clk_sdram) begin
    if (push_ok) mem[wr_ptr] <= rx_byte;
  end

  always_ff @(posedge clk_sdram or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      word        <= 16'h0;
      ioctl_wr    <= 1'b0;
      ioctl_addr  <= '0;
      ioctl_err   <= 1'b0;
      downloading <= 1'b0;
      end_pend    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else if (tx_start) begin
      state       <= IDLE;
      ioctl_wr    <= 1'b0;
      ioctl_addr  <= '0;
      ioctl_err   <= 1'b0;
      downloading <= 1'b1;
      end_pend    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      if (overflow) ioctl_err <= 1'b1;
      if (tx_end)   end_pend  <= 1'b1;

      case (state)
        IDLE: begin
          if (pop) begin
            if (DW == 8) begin
              word     <= {8'h00, head};
              ioctl_wr <= 1'b1;
              state    <= WRITE;
            end else begin
              word[7:0] <= head;
              state     <= HALF;
            end
          end else if (end_pend && fifo_empty) begin
            downloading <= 1'b0;
            end_pend    <= 1'b0;
          end
        end
        HALF: begin
          if (pop) begin
            word[15:8] <= head;
            ioctl_wr   <= 1'b1;
            state      <= WRITE;
          end else if (end_pend && fifo_empty) begin
            // Odd-length file: pad the last word
            word[15:8] <= 8'h00;
            ioctl_wr   <= 1'b1;
            state      <= WRITE;
          end
        end
        WRITE: begin
          if (ioctl_ready) begin
            ioctl_wr   <= 1'b0;
            ioctl_addr <= ioctl_addr + AW'(1);
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  generate
    if (DW == 16) begin : g_w16
      assign ioctl_data = word;
    end else begin : g_w8
      logic unused_hi;
      assign unused_hi  = ^word[15:8];
      assign ioctl_data = word[7:0];
    end
  endgenerate

`ifdef JTFRAME_DATA_IO_SUM_EN
  logic [15:0] sum;

  always_ff @(posedge clk_sdram or posedge rst) begin
    if (rst)           sum <= 16'h0;
    else if (tx_start) sum <= 16'h0;
    else if (pop)      sum <= sum + {8'h00, head};
  end

  assign ioctl_sum = sum;
`else
  assign ioctl_sum = 16'h0;
`endif

endmodule

// File: tb/tb_jtframe_data_io.sv
// tb/tb_jtframe_data_io.sv - scoreboard bench for jtframe_data_io, DW=8 and DW=16 instances on one SPI bus
`timescale 1ns/1ps
module tb_jtframe_data_io;
  localparam int AW = 4;
  localparam int DEPTH = 4;
`ifdef JTFRAME_DATA_IO_SUM_EN
  localparam bit SUM_EN = 1'b1;
`else
  localparam bit SUM_EN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, sck = 1'b0, ss = 1'b1, sdi = 1'b0, ioctl_ready = 1'b0;
  logic [7:0]    index8, index16, data8;
  logic [15:0]   data16, sum8, sum16;
  logic [AW-1:0] addr8, addr16;
  logic          dl8, dl16, wr8, wr16, err8, err16;

  always #5 clk = ~clk;

  jtframe_data_io #(.DW(8), .AW(AW), .DEPTH(DEPTH)) u8 (
    .clk_sdram(clk), .rst(rst), .sck(sck), .ss(ss), .sdi(sdi),
    .index(index8), .downloading(dl8), .ioctl_addr(addr8), .ioctl_data(data8),
    .ioctl_wr(wr8), .ioctl_ready(ioctl_ready), .ioctl_err(err8), .ioctl_sum(sum8));

  jtframe_data_io #(.DW(16), .AW(AW), .DEPTH(DEPTH)) u16 (
    .clk_sdram(clk), .rst(rst), .sck(sck), .ss(ss), .sdi(sdi),
    .index(index16), .downloading(dl16), .ioctl_addr(addr16), .ioctl_data(data16),
    .ioctl_wr(wr16), .ioctl_ready(ioctl_ready), .ioctl_err(err16), .ioctl_sum(sum16));

  typedef logic [7:0] bq_t[$];

  int checks = 0, errors = 0;
  bit hold = 1'b0;
  logic [31:0] exp8[$], exp16[$];

  // Reference model: file bytes become words at sequential addresses modulo 2^AW
  bit m_dl = 0, m_half = 0, m_err8 = 0, m_err16 = 0;
  int m_a8 = 0, m_a16 = 0;
  logic [7:0]  m_lo = 8'h0;
  logic [15:0] m_sum8 = 16'h0, m_sum16 = 16'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int a, input logic [15:0] d);
    logic [3:0] a4;
    a4 = 4'(a % (1 << AW));
    return {12'h0, a4, d};
  endfunction

  function automatic logic [15:0] sum_exp(input logic [15:0] s);
    return SUM_EN ? s : 16'h0;
  endfunction

  task automatic model_byte(input logic [7:0] c, input logic [7:0] b, input bit k8, input bit k16);
    if (c == 8'h53) begin
      if (b[0]) begin
        m_dl = 1; m_half = 0; m_a8 = 0; m_a16 = 0;
        m_sum8 = 0; m_sum16 = 0; m_err8 = 0; m_err16 = 0;
      end else begin
        if (m_dl && m_half) begin
          exp16.push_back(pk(m_a16, {8'h00, m_lo}));
          m_a16++;
          m_half = 0;
        end
        m_dl = 0;
      end
    end else if (c == 8'h54 && m_dl) begin
      if (k8) begin
        exp8.push_back(pk(m_a8, {8'h00, b}));
        m_a8++;
        m_sum8 += {8'h00, b};
      end else m_err8 = 1;
      if (k16) begin
        m_sum16 += {8'h00, b};
        if (!m_half) begin m_lo = b; m_half = 1; end
        else begin
          exp16.push_back(pk(m_a16, {b, m_lo}));
          m_a16++;
          m_half = 0;
        end
      end else m_err16 = 1;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input logic [7:0] v, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sdi = v[i]; sck = 1'b0; tick(3);
      sck = 1'b1; tick(3);
    end
  endtask

  task automatic send(input logic [7:0] c, input bq_t d, input int lim8, input int lim16);
    ss = 1'b0; tick(3);
    spi_bits(c, 8);
    foreach (d[i]) begin
      model_byte(c, d[i], i < lim8, i < lim16);
      spi_bits(d[i], 8);
    end
    sck = 1'b0; tick(3);
    ss = 1'b1; tick(4);
  endtask

  task automatic one(input logic [7:0] c, input logic [7:0] b);
    bq_t q;
    q.push_back(b);
    send(c, q, 99, 99);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((dl8 || dl16) && n < 3000) begin tick(1); n++; end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL %s_drain: downloading=%b%b expected 00", tag, dl8, dl16);
    end
    tick(3);
    check({tag, "_left8"}, 64'(exp8.size()), 64'd0);
    check({tag, "_left16"}, 64'(exp16.size()), 64'd0);
    check({tag, "_sum8"}, 64'(sum8), 64'(sum_exp(m_sum8)));
    check({tag, "_sum16"}, 64'(sum16), 64'(sum_exp(m_sum16)));
    check({tag, "_err"}, 64'({err8, err16}), 64'({m_err8, m_err16}));
  endtask

  initial forever begin
    @(posedge clk); #1;
    ioctl_ready = hold ? 1'b0 : 1'($urandom_range(0, 1));
  end

  initial forever begin
    @(negedge clk);
    if (!rst && ioctl_ready) begin
      if (wr8) begin
        if (exp8.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr8: got write addr %0h data %0h expected none", addr8, data8);
        end else check("wr8", 64'({12'h0, addr8, 8'h00, data8}), 64'(exp8.pop_front()));
      end
      if (wr16) begin
        if (exp16.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr16: got write addr %0h data %0h expected none", addr16, data16);
        end else check("wr16", 64'({12'h0, addr16, data16}), 64'(exp16.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500us, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t q;
    int n, len;
    tick(5);
    check("reset8", 64'({index8, dl8, addr8, data8, wr8, err8, sum8}), 64'd0);
    check("reset16", 64'({index16, dl16, addr16, data16, wr16, err16, sum16}), 64'd0);
    rst = 1'b0;
    tick(5);

    // 0x11 0x22 0x33
    one(8'h53, 8'h01);
    q = {8'h11, 8'h22, 8'h33};
    send(8'h54, q, 99, 99);
    one(8'h53, 8'h00);
    wait_drain("s123");
    check("s123_sum_const", 64'(sum8), 64'(sum_exp(16'h0066)));

    // 0xAA 0xBB 0xCC: odd length exercises the DW=16 pad
    one(8'h53, 8'h01);
    q = {8'hAA, 8'hBB, 8'hCC};
    send(8'h54, q, 99, 99);
    one(8'h53, 8'h00);
    wait_drain("sabc");
    check("sabc_sum_const", 64'(sum16), 64'(sum_exp(16'h0231)));

    one(8'h55, 8'h1F);
    tick(5);
    check("index", 64'({index8, index16}), 64'h1F1F);

    q = {8'hDE, 8'hAD};
    send(8'h54, q, 99, 99);
    tick(20);
    check("idle_no_wr", 64'({wr8, wr16, dl8, dl16}), 64'd0);

    // Partial data byte cut off by ss
    one(8'h53, 8'h01);
    ss = 1'b0; tick(3);
    spi_bits(8'h54, 8);
    spi_bits(8'hA5, 4);
    sck = 1'b0; tick(3);
    ss = 1'b1; tick(4);
    one(8'h54, 8'h3C);
    one(8'h53, 8'h00);
    wait_drain("abort");

    // Stalled loader: write stage holds DW/8 bytes, FIFO holds DEPTH, the rest is dropped
    hold = 1'b1; tick(2);
    one(8'h53, 8'h01);
    q = {};
    for (int i = 0; i < 7; i++) q.push_back(8'($urandom));
    send(8'h54, q, DEPTH + 1, DEPTH + 2);
    tick(20);
    check("ovf_err", 64'({err8, err16}), 64'b11);
    hold = 1'b0;
    one(8'h53, 8'h00);
    wait_drain("ovf");
    one(8'h53, 8'h01);
    tick(3);
    check("ovf_err_clr", 64'({err8, err16}), 64'd0);
    one(8'h53, 8'h00);
    wait_drain("ovf_clr");

    // Random files, long enough to wrap the 4-bit address
    for (int s = 0; s < 5; s++) begin
      one(8'h53, 8'h01);
      len = (s == 0) ? 20 : $urandom_range(1, 20);
      q = {};
      for (int i = 0; i < len; i++) q.push_back(8'($urandom));
      send(8'h54, q, 99, 99);
      one(8'h53, 8'h00);
      wait_drain("rand");
    end

    // Reset while both instances hold a write
    hold = 1'b1; tick(2);
    one(8'h53, 8'h01);
    q = {8'h5A, 8'hC3};
    send(8'h54, q, 99, 99);
    n = 0;
    while (!(wr8 && wr16) && n < 500) begin tick(1); n++; end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL rst_wr_wait: wr=%b%b expected 11", wr8, wr16);
    end
    rst = 1'b1;
    #1;
    check("rst_mid8", 64'({index8, dl8, addr8, data8, wr8, err8, sum8}), 64'd0);
    check("rst_mid16", 64'({index16, dl16, addr16, data16, wr16, err16, sum16}), 64'd0);
    tick(2);
    exp8.delete(); exp16.delete();
    m_dl = 0; m_half = 0;
    rst = 1'b0; hold = 1'b0;
    tick(10);
    check("post_rst", 64'({wr8, wr16, dl8, dl16}), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
